c2c_rx_deframer: RTL
====================

# c2c_rx_deframer

Receive-side frame extractor for the chip-to-chip link. It sits directly downstream of the 8:1 deserializer and its bitslip trainer, running on the divided clock. It consumes aligned parallel bytes, hunts for start-of-frame, and checks length and checksum. Each good frame is buffered whole and released on a valid/ready byte stream; bad frames are dropped and flagged.

## Interface
- MAX_LEN, 16: maximum payload bytes per frame (1..255); sets buffer depth.
- SOF, 8'hA5: start-of-frame marker byte.
- IDLE, 8'h0A: training/idle byte; ignored while hunting.
- TIMEOUT, 255: maximum clkdiv cycles without `q_valid` inside a frame before abort.

Ports:
- clkdiv  in  1  single clock (divided link clock); all logic on rising edge.
- rst  in  1  asynchronous active-low reset.
- q  in  8  parallel byte from deserializer, MSB first on the wire.
- q_valid  in  1  `q` holds a new byte this cycle (deserializer clock enable).
- aligned  in  1  bitslip training complete; bytes are ignored while low.
- m_data  out  8  payload byte.
- m_valid  out  1  `m_data` valid.
- m_last  out  1  final payload byte of frame.
- m_ready  in  1  downstream accepts beat.
- frame_ok  out  1  one-cycle pulse: good frame captured.
- frame_err  out  1  one-cycle pulse: frame aborted.
- err_code  out  2  cause, valid with `frame_err`: 00 bad length, 01 checksum, 10 timeout, 11 alignment lost.
- drop_cnt  out  16  count of SOF bytes discarded while draining; saturates at 16'hFFFF.

## Operation
- Frame on the wire: SOF, LEN, LEN payload bytes, CSUM. CSUM = XOR of LEN and all payload bytes.
- A byte is accepted only when `q_valid && aligned`.
- HUNT: waits for an accepted byte equal to SOF; all other bytes, including IDLE, are discarded. SOF -> LEN.
- LEN: if the accepted byte is 0 or greater than MAX_LEN -> `frame_err`/00, then HUNT. Otherwise store LEN, seed the checksum with it, clear the index, and go to PAYLOAD.
- PAYLOAD: write the byte to `buf[idx]`, XOR it into the checksum, and increment idx. Go to CSUM after byte LEN-1 is accepted.
- CSUM: if the byte equals the accumulated checksum -> `frame_ok`, then DRAIN. On mismatch -> `frame_err`/01, then HUNT.
- DRAIN:
  - `m_valid`=1, `m_data`=`buf[rd_idx]`, `m_last`=(`rd_idx`==LEN-1).
  - `rd_idx` increments on `m_valid && m_ready`.
  - After the last beat transfers, return to HUNT.
  - Incoming bytes are not stored; each accepted SOF increments `drop_cnt`.
- Timeout: in LEN, PAYLOAD or CSUM, a counter reloads on every accepted byte. If TIMEOUT cycles pass with no accepted byte -> `frame_err`/10, then HUNT.
- `aligned` falling in LEN, PAYLOAD or CSUM -> `frame_err`/11, then HUNT. A fall during DRAIN does not affect the frame being drained.
- Only one error cause can occur per cycle. When both apply, alignment loss takes priority over byte processing and timeout.

## Timing
- Reset values: `m_valid`=0, `m_last`=0, `m_data`=0, `frame_ok`=0, `frame_err`=0, `err_code`=0, `drop_cnt`=0; state=HUNT, all counters 0.
- `frame_ok` and `frame_err` are registered and assert in the cycle after the deciding byte is sampled.
- `m_valid` rises in the same cycle as `frame_ok`, so the first payload byte is available 1 cycle after CSUM is sampled.
- Drain throughput is 1 byte/cycle with `m_ready` held high. `m_valid` and `m_data` stay stable while `m_ready`=0.
- HUNT is entered the cycle after the last beat transfers. SOF bytes arriving in DRAIN are lost, so the transmitter must leave at least LEN+1 IDLE bytes between frames.
- An asynchronous reset mid-frame or mid-drain clears all state immediately. No pulse is generated.

## Structure
- Shared package `c2c_pkg`: state enum (HUNT, LEN, PAYLOAD, CSUM, DRAIN), err_code localparams, default SOF/IDLE constants. The matching transmit framer reuses the same package.
- One sub-module, `c2c_frame_buf`: MAX_LEN x 8 register file with synchronous write and asynchronous read. No reset on its storage.

## Test plan
- LEN=3, payload 11 22 33, CSUM=03, `m_ready`=1 -> `frame_ok` pulse; beats 11,22,33 on consecutive cycles with `m_last` on 33; then HUNT.
- Same frame with CSUM=04 -> `frame_err`, `err_code`=01, `m_valid` never rises.
- LEN=0, and separately LEN=MAX_LEN+1 (17) -> `frame_err`/00 after the LEN byte; a following good frame is accepted.
- SOF, LEN=2, byte AA, then `q_valid` low for 256 cycles -> `frame_err`/10 at TIMEOUT; a later frame is accepted.
- `aligned` drops after the 2nd payload byte -> `frame_err`/11. Separately, while draining a frame with `m_ready`=0, send two SOF bytes -> `drop_cnt`=2 and the buffered frame still drains intact.
- Assert reset during DRAIN -> all outputs return to reset values asynchronously; the next good frame after release decodes correctly.

Source files
------------

// File: rtl/c2c_pkg.sv
// c2c_pkg: shared types and constants for the chip-to-chip link framers.
package c2c_pkg;
  typedef enum logic [2:0] {HUNT, LEN, PAYLOAD, CSUM, DRAIN} state_t;
  localparam logic [1:0] ERR_LEN   = 2'b00;
  localparam logic [1:0] ERR_CSUM  = 2'b01;
  localparam logic [1:0] ERR_TMO   = 2'b10;
  localparam logic [1:0] ERR_ALIGN = 2'b11;
  localparam logic [7:0] C2C_SOF  = 8'hA5;
  localparam logic [7:0] C2C_IDLE = 8'h0A;
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return &v ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/c2c_frame_buf.sv
// c2c_frame_buf: payload register file, synchronous write, asynchronous read, unreset storage.
module c2c_frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);
  logic [7:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/c2c_rx_deframer.sv
// c2c_rx_deframer: hunts SOF, checks length/checksum, buffers good frames and drains them on valid/ready.
module c2c_rx_deframer
  import c2c_pkg::*;
#(
  parameter int MAX_LEN = 16,
  parameter logic [7:0] SOF = C2C_SOF,
  parameter int TIMEOUT = 255
) (
  input  logic        clkdiv,
  input  logic        rst,
  input  logic [7:0]  q,
  input  logic        q_valid,
  input  logic        aligned,
  output logic [7:0]  m_data,
  output logic        m_valid,
  output logic        m_last,
  input  logic        m_ready,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic [15:0] drop_cnt
);
  localparam int AW = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [7:0] MAX_B = 8'(MAX_LEN);
  state_t state;
  logic [7:0] len, idx, rd_idx, csum, rdata;
  logic [TW-1:0] tmo;
  logic acc, in_frame, beat;
  assign acc = q_valid && aligned;
  assign in_frame = state inside {LEN, PAYLOAD, CSUM};
  assign beat = m_valid && m_ready;
  assign m_data = m_valid ? rdata : '0;
  assign m_last = m_valid && rd_idx == len - 8'd1;
  c2c_frame_buf #(.DEPTH(MAX_LEN), .AW(AW)) u_buf (
    .clk(clkdiv),
    .we(state == PAYLOAD && acc),
    .waddr(idx[AW-1:0]),
    .wdata(q),
    .raddr(rd_idx[AW-1:0]),
    .rdata(rdata)
  );
  always_ff @(posedge clkdiv or negedge rst) begin
    if (!rst) begin
      state <= HUNT;
      len <= '0;
      idx <= '0;
      rd_idx <= '0;
      csum <= '0;
      tmo <= '0;
      m_valid <= 1'b0;
      frame_ok <= 1'b0;
      frame_err <= 1'b0;
      err_code <= '0;
      drop_cnt <= '0;
    end else begin
      frame_ok <= 1'b0;
      frame_err <= 1'b0;
      if (in_frame) tmo <= acc ? '0 : tmo + 1'b1;
      // alignment loss outranks both byte processing and timeout
      if (in_frame && !aligned) begin
        frame_err <= 1'b1;
        err_code <= ERR_ALIGN;
        state <= HUNT;
      end else if (in_frame && !q_valid && tmo == TW'(TIMEOUT - 1)) begin
        frame_err <= 1'b1;
        err_code <= ERR_TMO;
        state <= HUNT;
      end else begin
        case (state)
          HUNT: if (acc && q == SOF) begin
            state <= LEN;
            tmo <= '0;
          end
          LEN: if (acc) begin
            if (q == 8'd0 || q > MAX_B) begin
              frame_err <= 1'b1;
              err_code <= ERR_LEN;
              state <= HUNT;
            end else begin
              len <= q;
              csum <= q;
              idx <= '0;
              state <= PAYLOAD;
            end
          end
          PAYLOAD: if (acc) begin
            csum <= csum ^ q;
            idx <= idx + 8'd1;
            if (idx == len - 8'd1) state <= CSUM;
          end
          CSUM: if (acc) begin
            if (q == csum) begin
              frame_ok <= 1'b1;
              m_valid <= 1'b1;
              rd_idx <= '0;
              state <= DRAIN;
            end else begin
              frame_err <= 1'b1;
              err_code <= ERR_CSUM;
              state <= HUNT;
            end
          end
          DRAIN: begin
            if (acc && q == SOF) drop_cnt <= sat_inc(drop_cnt);
            if (beat) begin
              if (m_last) begin
                m_valid <= 1'b0;
                state <= HUNT;
              end else rd_idx <= rd_idx + 8'd1;
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end
endmodule
